// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and types.
// Reused by every AHB2 slave in this codebase.
package ahb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_8BITS  = 3'b000;
  localparam logic [2:0] HSIZE_16BITS = 3'b001;
  localparam logic [2:0] HSIZE_32BITS = 3'b010;

  // Two-cycle ERROR response sequencing
  typedef enum logic [1:0] {
    OKAY_ST = 2'd0,
    ERR1    = 2'd1,
    ERR2    = 2'd2
  } ahb2_err_st_e;

endpackage

// File: rtl/ahb2_wstrb_gen.sv
// Little-endian byte-lane strobe decode for a 32-bit AHB2 data bus.
// Flags misaligned and oversize transfers.
module ahb2_wstrb_gen
  import ahb2_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] hsize,
  output logic [3:0] strb,
  output logic       err
);

  always_comb begin
    strb = 4'b0000;
    err  = 1'b0;
    case (hsize)
      HSIZE_8BITS: begin
        strb = 4'b0001 << addr_lo;
      end
      HSIZE_16BITS: begin
        strb = addr_lo[1] ? 4'b1100 : 4'b0011;
        err  = addr_lo[0];
      end
      HSIZE_32BITS: begin
        strb = 4'b1111;
        err  = |addr_lo;
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb2_sram_slave.sv
// Zero-wait AHB2 SRAM slave with write-data bypass and
// two-cycle ERROR response for bad size/alignment/range.
module ahb2_sram_slave
  import ahb2_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hready,
  input  logic [31:0]       hwdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [31:0]       hrdata
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [3:0] strb;
  logic       size_err;

  ahb2_wstrb_gen u_strb (
    .addr_lo (haddr[1:0]),
    .hsize   (hsize),
    .strb    (strb),
    .err     (size_err)
  );

  ahb2_err_st_e state_q, state_d;

  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [3:0]    wr_strb_q, wr_strb_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic          accept;
  logic          range_err;
  logic          xfer_err;
  logic          xfer_ok;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign unused_ok = ^{hburst, htrans[0]};

  assign accept    = hsel & hready & htrans[1]
                   & (state_q != ERR1);
  assign range_err = (haddr >> (AW + 2)) != '0;
  assign xfer_err  = accept & (size_err | range_err);
  assign xfer_ok   = accept & ~xfer_err;
  assign idx       = haddr[AW+1:2];

  // Read merges lanes of a write still in its data phase
  always_comb begin
    rd_word = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_pend_q && (wr_idx_q == idx) && wr_strb_q[b]) begin
        rd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OKAY_ST: if (xfer_err) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = xfer_err ? ERR1 : OKAY_ST;
      default: state_d = OKAY_ST;
    endcase
  end

  always_comb begin
    wr_pend_d = xfer_ok & hwrite;
    wr_idx_d  = wr_idx_q;
    wr_strb_d = wr_strb_q;
    hrdata_d  = hrdata_q;
    if (xfer_ok && hwrite) begin
      wr_idx_d  = idx;
      wr_strb_d = strb;
    end
    if (xfer_ok && !hwrite) begin
      hrdata_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OKAY_ST;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_strb_q <= 4'b0000;
      hrdata_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      wr_strb_q <= wr_strb_d;
      hrdata_q  <= hrdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pend_q && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_q[b]) begin
          mem[wr_idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  assign hreadyout = (state_q != ERR1);
  assign hresp     = (state_q == OKAY_ST) ? HRESP_OKAY
                                          : HRESP_ERROR;
  assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb2_sram_slave.sv
// Directed bench for ahb2_sram_slave: one table row per clock,
// plus hand-written reset sequences.
module tb_ahb2_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Single-slave bus: HREADY is this slave's own HREADYOUT
  assign hready = hreadyout;

  ahb2_sram_slave #(.ADDR_W(32), .DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hready    (hready),
    .hwdata    (hwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic [1:0]  resp;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BY = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] ER = 2'b01;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h",
               name, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic [1:0] tr,
                     input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic rdy, input logic [1:0] rsp,
                     input logic crd, input logic [31:0] rd);
    vec_t v;
    v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz;
    v.addr = a; v.wd = wd; v.rdy = rdy; v.resp = rsp;
    v.chk_rd = crd; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr,
                       input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz;
    haddr = a; hwdata = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    hburst = 3'b000;
    rst = 1'b1;
    drive(1'b0, ID, 1'b0, 3'd2, 32'h0, 32'h0);
    tick; tick;
    chk("reset_hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("reset_hresp", {30'b0, hresp}, 32'd0);
    chk("reset_hrdata", hrdata, 32'h0);
    rst = 1'b0;

    //  sel tr  wr    sz    addr          wd           rdy  rsp crd rd
    add(1, NS, 1, 3'd2, 32'h0000, 32'h0,        1, OK, 0, 32'h0);
    add(1, NS, 1, 3'd2, 32'h0010, 32'h12345678, 1, OK, 0, 32'h0);
    add(1, ID, 0, 3'd2, 32'h0000, 32'hDEADBEEF, 1, OK, 0, 32'h0);
    add(1, NS, 0, 3'd2, 32'h0010, 32'h0,        1, OK, 1, 32'hDEADBEEF);
    add(1, NS, 1, 3'd2, 32'h0020, 32'h0,        1, OK, 0, 32'h0);
    add(1, NS, 1, 3'd0, 32'h0022, 32'h11223344, 1, OK, 0, 32'h0);
    add(1, ID, 0, 3'd2, 32'h0000, 32'h00AA0000, 1, OK, 0, 32'h0);
    add(1, NS, 0, 3'd2, 32'h0020, 32'h0,        1, OK, 1, 32'h11AA3344);
    add(1, NS, 1, 3'd2, 32'h0040, 32'h0,        1, OK, 0, 32'h0);
    add(1, SQ, 0, 3'd2, 32'h0040, 32'hCAFEF00D, 1, OK, 1, 32'hCAFEF00D);
    add(1, NS, 0, 3'd2, 32'h0003, 32'h0,        0, ER, 0, 32'h0);
    add(1, ID, 0, 3'd2, 32'h0000, 32'h0,        1, ER, 0, 32'h0);
    add(1, NS, 1, 3'd2, 32'h0002, 32'h0,        0, ER, 0, 32'h0);
    add(1, ID, 0, 3'd2, 32'h0000, 32'hFFFFFFFF, 1, ER, 0, 32'h0);
    add(1, NS, 0, 3'd2, 32'h1000, 32'h0,        0, ER, 0, 32'h0);
    add(1, ID, 0, 3'd2, 32'h0000, 32'h0,        1, ER, 0, 32'h0);
    add(1, NS, 0, 3'd2, 32'h0000, 32'h0,        1, OK, 1, 32'h12345678);
    add(1, NS, 0, 3'd0, 32'h0041, 32'h0,        1, OK, 1, 32'hCAFEF00D);
    add(1, NS, 1, 3'd1, 32'h0042, 32'h0,        1, OK, 0, 32'h0);
    add(1, NS, 0, 3'd2, 32'h0040, 32'hBEEF0000, 1, OK, 1, 32'hBEEFF00D);
    add(1, NS, 0, 3'd3, 32'h0000, 32'h0,        0, ER, 0, 32'h0);
    add(1, ID, 0, 3'd2, 32'h0000, 32'h0,        1, ER, 0, 32'h0);
    add(1, BY, 0, 3'd2, 32'h0000, 32'h0,        1, OK, 1, 32'hBEEFF00D);
    add(0, NS, 1, 3'd2, 32'h0040, 32'h0,        1, OK, 1, 32'hBEEFF00D);
    add(1, NS, 0, 3'd2, 32'h0040, 32'h11111111, 1, OK, 1, 32'hBEEFF00D);
    add(1, NS, 0, 3'd1, 32'h0041, 32'h0,        0, ER, 0, 32'h0);
    add(1, ID, 0, 3'd2, 32'h0000, 32'h0,        1, ER, 0, 32'h0);
    add(1, NS, 0, 3'd1, 32'h0022, 32'h0,        1, OK, 1, 32'h11AA3344);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].trans, vecs[i].wr,
            vecs[i].size, vecs[i].addr, vecs[i].wd);
      tick;
      chk($sformatf("v%0d_hreadyout", i),
          {31'b0, hreadyout}, {31'b0, vecs[i].rdy});
      chk($sformatf("v%0d_hresp", i),
          {30'b0, hresp}, {30'b0, vecs[i].resp});
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_hrdata", i), hrdata, vecs[i].rd);
    end

    // Reset lands on a write data phase: write discarded
    drive(1'b1, NS, 1'b1, 3'd2, 32'h0010, 32'h0);
    tick;
    drive(1'b0, ID, 1'b0, 3'd2, 32'h0, 32'h55555555);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_wr_hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("rst_wr_hresp", {30'b0, hresp}, 32'd0);
    chk("rst_wr_hrdata", hrdata, 32'h0);
    drive(1'b1, NS, 1'b0, 3'd2, 32'h0010, 32'h0);
    tick;
    chk("rst_wr_unchanged", hrdata, 32'hDEADBEEF);

    // Reset while in ERR1 returns to OKAY
    drive(1'b1, NS, 1'b0, 3'd2, 32'h0001, 32'h0);
    tick;
    chk("pre_rst_err1", {31'b0, hreadyout}, 32'd0);
    drive(1'b0, ID, 1'b0, 3'd2, 32'h0, 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_err_hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("rst_err_hresp", {30'b0, hresp}, 32'd0);
    tick;
    chk("rst_err_stays_okay", {30'b0, hresp}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
